// File: rtl/branch_predict_btb.sv
// Branch target buffer with saturating direction counters.
// Lookup (IF) is combinational on lookup_pc; update (EX/MEM) writes the resolved
// outcome at the rising edge; mispredict/redirect_pc are combinational on the
// update inputs; statistics are saturating registered counters.
// Ports:
//   CLK, nRST                       clock, async active-low reset
//   lookup_en, lookup_pc            IF lookup (lookup_en only qualifies statistics)
//   pred_hit, pred_taken, pred_npc  combinational prediction for lookup_pc
//   update_*                        resolved control-flow instruction
//   mispredict, redirect_pc         combinational resolve result
//   flush_all                       invalidate every entry at the next edge
//   stat_lookups, stat_mispred      saturating statistics counters
module branch_predict_btb #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned STAT_W   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              lookup_en,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_npc,
    input  logic              update_en,
    input  logic [31:0]       update_pc,
    input  logic              update_taken,
    input  logic [31:0]       update_target,
    input  logic              update_pred_tkn,
    input  logic [31:0]       update_pred_npc,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    input  logic              flush_all,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;

    // pc[1:0] and the carried prediction direction carry no information here
    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0], update_pred_tkn};

    // Lookup path: index/tag split and prediction
    always_comb begin
        lk_idx     = lookup_pc[IDX_W+1:2];
        lk_tag     = lookup_pc[31:IDX_W+2];
        pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
        pred_npc   = pred_taken ? target_q[lk_idx] : (lookup_pc + 32'd4);
    end

    // Resolve path: actual next PC compared with the prediction carried down the pipe
    always_comb begin
        up_idx      = update_pc[IDX_W+1:2];
        up_tag      = update_pc[31:IDX_W+2];
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        redirect_pc = update_taken ? update_target : (update_pc + 32'd4);
        mispredict  = update_en && (redirect_pc != update_pred_npc);
    end

    // Entry storage; flush wins over a same-cycle update
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (update_en) begin
            if (up_hit) begin
                if (update_taken) begin
                    target_q[up_idx] <= update_target;
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
                    end
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
                end
            end else if (update_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
                ctr_q[up_idx]    <= CTR_WEAK;
            end
        end
    end

    // Saturating statistics, untouched by flush
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else begin
            if (lookup_en && (stat_lookups != '1)) begin
                stat_lookups <= stat_lookups + STAT_W'(1);
            end
            if (mispredict && (stat_mispred != '1)) begin
                stat_mispred <= stat_mispred + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_btb.sv
// Scoreboard bench for branch_predict_btb: stimulus pushes hand-computed
// expectations into a queue; a monitor on the falling edge pops and compares.
module tb_branch_predict_btb;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        lookup_en = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_pred_tkn = 1'b0;
    logic [31:0] update_pred_npc = '0;
    logic        flush_all = 1'b0;

    logic        pred_hit, pred_taken, mispredict;
    logic [31:0] pred_npc, redirect_pc, stat_lookups, stat_mispred;
    logic        pred_hit4, pred_taken4, mispredict4;
    logic [31:0] pred_npc4, redirect_pc4;
    logic [3:0]  stat_lookups4, stat_mispred4;

    always #5 CLK = ~CLK;

    branch_predict_btb u_dut (
        .CLK(CLK), .nRST(nRST),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_tkn(update_pred_tkn),
        .update_pred_npc(update_pred_npc),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .flush_all(flush_all),
        .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
    );

    branch_predict_btb #(.STAT_W(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit4), .pred_taken(pred_taken4), .pred_npc(pred_npc4),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_tkn(update_pred_tkn),
        .update_pred_npc(update_pred_npc),
        .mispredict(mispredict4), .redirect_pc(redirect_pc4),
        .flush_all(flush_all),
        .stat_lookups(stat_lookups4), .stat_mispred(stat_mispred4)
    );

    typedef enum int {K_HIT, K_TKN, K_NPC, K_MISP, K_REDIR, K_STL, K_STM, K_STL4, K_STM4} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        int          step;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad = 0;
    int    n_lk = 0;
    int    n_mp = 0;
    logic  cur_mp = 1'b0;
    int    step = 0;

    function automatic string kname(kind_t k);
        case (k)
            K_HIT:   return "pred_hit";
            K_TKN:   return "pred_taken";
            K_NPC:   return "pred_npc";
            K_MISP:  return "mispredict";
            K_REDIR: return "redirect_pc";
            K_STL:   return "stat_lookups";
            K_STM:   return "stat_mispred";
            K_STL4:  return "stat_lookups_w4";
            default: return "stat_mispred_w4";
        endcase
    endfunction

    function automatic logic [31:0] sat4(int n);
        return (n > 15) ? 32'd15 : 32'(n);
    endfunction

    task automatic push(kind_t k, logic [31:0] e);
        item_t it;
        it.kind = k;
        it.exp  = e;
        it.step = step;
        q.push_back(it);
    endtask

    // One cycle of stimulus: account for what the last edge consumed, then drive
    task automatic cyc(input logic le, input logic [31:0] lpc,
                       input logic ue, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic [31:0] upn,
                       input logic fl, input logic exp_mp);
        @(posedge CLK);
        #1;
        if (lookup_en) n_lk++;
        if (cur_mp) n_mp++;
        step++;
        lookup_en       = le;
        lookup_pc       = lpc;
        update_en       = ue;
        update_pc       = upc;
        update_taken    = ut;
        update_target   = utg;
        update_pred_npc = upn;
        update_pred_tkn = 1'b0;
        flush_all       = fl;
        cur_mp          = ue & exp_mp;
        push(K_MISP, {31'd0, ue & exp_mp});
    endtask

    task automatic idle(input logic le, input logic [31:0] lpc);
        cyc(le, lpc, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_pred(input logic hit, input logic tkn, input logic [31:0] npc);
        push(K_HIT, {31'd0, hit});
        push(K_TKN, {31'd0, tkn});
        push(K_NPC, npc);
    endtask

    task automatic chk_stats();
        push(K_STL,  32'(n_lk));
        push(K_STM,  32'(n_mp));
        push(K_STL4, sat4(n_lk));
        push(K_STM4, sat4(n_mp));
    endtask

    // Monitor: compare every pending expectation against the settled outputs
    always @(negedge CLK) begin : monitor
        item_t       it;
        logic [31:0] act;
        while (q.size() > 0) begin
            it = q.pop_front();
            case (it.kind)
                K_HIT:   act = {31'd0, pred_hit};
                K_TKN:   act = {31'd0, pred_taken};
                K_NPC:   act = pred_npc;
                K_MISP:  act = {31'd0, mispredict};
                K_REDIR: act = redirect_pc;
                K_STL:   act = stat_lookups;
                K_STM:   act = stat_mispred;
                K_STL4:  act = {28'd0, stat_lookups4};
                default: act = {28'd0, stat_mispred4};
            endcase
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h",
                         kname(it.kind), it.step, act, it.exp);
            end
        end
    end

    logic [4:0] tkn_seq;

    initial begin
        #12 nRST = 1'b1;

        // Reset state
        idle(1'b1, 32'h40);
        chk_pred(1'b0, 1'b0, 32'h44);
        chk_stats();

        // Allocate 0x40 -> 0x100; not visible in the same cycle
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 32'h44, 1'b0, 1'b1);
        push(K_REDIR, 32'h100);
        chk_pred(1'b0, 1'b0, 32'h44);
        idle(1'b1, 32'h40);
        chk_pred(1'b1, 1'b1, 32'h100);
        chk_stats();

        // Counter down 2->1->0
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 32'h100, 1'b0, 1'b1);
        push(K_REDIR, 32'h44);
        chk_pred(1'b1, 1'b1, 32'h100);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 32'h44, 1'b0, 1'b0);
        chk_pred(1'b1, 1'b0, 32'h44);

        // Five taken updates; lookup shows ctr 0,1,2,3,3
        tkn_seq = 5'b11100;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 32'h100, 1'b0, 1'b0);
            chk_pred(1'b1, tkn_seq[i], tkn_seq[i] ? 32'h100 : 32'h44);
        end
        idle(1'b1, 32'h40);
        chk_pred(1'b1, 1'b1, 32'h100);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 32'h44, 1'b0, 1'b0);
        chk_pred(1'b1, 1'b1, 32'h100);
        idle(1'b1, 32'h40);
        chk_pred(1'b1, 1'b1, 32'h100);

        // Aliasing: 0x80 shares index 0 with 0x40
        cyc(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 32'h84, 1'b0, 1'b1);
        push(K_REDIR, 32'h300);
        chk_pred(1'b0, 1'b0, 32'h84);
        idle(1'b1, 32'h40);
        chk_pred(1'b0, 1'b0, 32'h44);
        cyc(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h400, 32'h300, 1'b0, 1'b1);
        push(K_REDIR, 32'h400);
        chk_pred(1'b1, 1'b1, 32'h300);
        idle(1'b1, 32'h80);
        chk_pred(1'b1, 1'b1, 32'h400);
        chk_stats();

        // Direction error then target error
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 32'h44, 1'b0, 1'b1);
        push(K_REDIR, 32'h100);
        chk_pred(1'b0, 1'b0, 32'h44);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 32'h104, 1'b0, 1'b1);
        push(K_REDIR, 32'h100);
        chk_pred(1'b1, 1'b1, 32'h100);

        // Flush beats same-cycle allocation at 0x2C
        cyc(1'b1, 32'h40, 1'b1, 32'h2C, 1'b1, 32'h500, 32'h30, 1'b1, 1'b1);
        push(K_REDIR, 32'h500);
        chk_pred(1'b1, 1'b1, 32'h100);
        idle(1'b1, 32'h40);
        chk_pred(1'b0, 1'b0, 32'h44);
        idle(1'b1, 32'h2C);
        chk_pred(1'b0, 1'b0, 32'h30);
        idle(1'b1, 32'h80);
        chk_pred(1'b0, 1'b0, 32'h84);
        chk_stats();

        // PC+4 wraps; lookup_en=0 is not counted
        cyc(1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        push(K_REDIR, 32'h0);
        chk_pred(1'b0, 1'b0, 32'h0);
        idle(1'b0, 32'hFFFF_FFFC);
        chk_stats();

        // Twenty mispredicts drive the 4-bit counters into saturation
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            push(K_REDIR, 32'h204);
        end
        idle(1'b0, 32'h200);
        chk_stats();
        idle(1'b0, 32'h200);
        chk_stats();

        repeat (2) @(negedge CLK);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
